// File: rtl/adc_pkg.sv
`default_nettype none
// ---- adc_pkg : shared widths and request-FSM encoding for adc_stream_framer ----
// ---- Rev 1.0                                                               ----
package adc_pkg;

  localparam int ADC_DATA_W  = 12;
  localparam int AXIS_DATA_W = 16;
  localparam int SEQ_TAG_W   = 4;

  typedef enum logic [0:0] {
    IDLE        = 1'b0,
    WAIT_RESULT = 1'b1
  } req_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sync_fifo.sv
`default_nettype none
// ---- adc_sync_fifo : first-word-fall-through FIFO, write refused when full ----
// ---- Rev 1.0                                                              ----
module adc_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Wr_En,
  input  logic [WIDTH-1:0] i_Wr_Data,
  output logic             o_Full,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_Empty   = (r_wr_ptr == r_rd_ptr);
  assign o_Full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_wr_fire = i_Wr_En && !o_Full;
  assign w_rd_fire = i_Rd_En && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Memory is not reset, so the head word is masked while empty.
  assign o_Rd_Data = o_Empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/adc_stream_framer.sv
`default_nettype none
// ---- adc_stream_framer : paces ADC requests, buffers results, frames AXI4-Stream ----
// ---- Rev 1.0  optional 4-bit sequence tag in o_Tdata[15:12]: ADC_FRAMER_SEQ_TAG_EN ----
module adc_stream_framer
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD_CLKS = 1000,
  parameter int FRAME_LEN          = 256,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Enable,
  output logic                   o_ADC_Data_Requested,
  input  logic                   i_ADC_Data_Valid,
  input  logic [ADC_DATA_W-1:0]  i_ADC_Data,
  output logic [AXIS_DATA_W-1:0] o_Tdata,
  output logic                   o_Tvalid,
  input  logic                   i_Tready,
  output logic                   o_Tlast,
  output logic                   o_Overflow,
  output logic                   o_Missed,
  input  logic                   i_Clear_Flags
);

`ifdef ADC_FRAMER_SEQ_TAG_EN
  localparam int FIFO_W = SEQ_TAG_W + ADC_DATA_W + 1;
`else
  localparam int FIFO_W = ADC_DATA_W + 1;
`endif

  localparam logic [15:0] c_period_last = 16'(SAMPLE_PERIOD_CLKS - 1);
  localparam logic [15:0] c_frame_last  = 16'(FRAME_LEN - 1);

  logic [15:0]       r_period_cnt;
  logic [15:0]       r_frame_idx;
  req_state_t        r_state;
  req_state_t        w_state_next;
  logic              w_tick;
  logic              w_request;
  logic              w_set_missed;
  logic              w_set_overflow;
  logic              w_wr_fire;
  logic              w_last;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FIFO_W-1:0] w_wr_data;
  logic [FIFO_W-1:0] w_rd_data;
  logic              r_overflow;
  logic              r_missed;

  // Reset gates the tick so no request pulse leaks out while i_Reset_n is low.
  assign w_tick = i_Reset_n && i_Enable && (r_period_cnt == 16'd0);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_period_cnt <= 16'd0;
    end else if (!i_Enable || (r_period_cnt == c_period_last)) begin
      r_period_cnt <= 16'd0;
    end else begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_request    = 1'b0;
    w_set_missed = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_request    = 1'b1;
          w_state_next = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        w_set_missed = w_tick;
        if (i_ADC_Data_Valid) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_ADC_Data_Requested = w_request;

  // Any strobe is captured, even one arriving with nothing outstanding.
  assign w_wr_fire      = i_ADC_Data_Valid && !w_fifo_full;
  assign w_set_overflow = i_ADC_Data_Valid && w_fifo_full;
  assign w_last         = (r_frame_idx == c_frame_last);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_frame_idx <= 16'd0;
    end else if (w_wr_fire) begin
      r_frame_idx <= w_last ? 16'd0 : r_frame_idx + 16'd1;
    end
  end

`ifdef ADC_FRAMER_SEQ_TAG_EN
  logic [SEQ_TAG_W-1:0] r_seq_tag;

  // Tag advances on dropped strobes too, so gaps downstream reveal overflow.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_seq_tag <= '0;
    end else if (i_ADC_Data_Valid) begin
      r_seq_tag <= r_seq_tag + {{(SEQ_TAG_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_wr_data = {r_seq_tag, i_ADC_Data, w_last};
  assign o_Tdata   = {w_rd_data[FIFO_W-1 -: SEQ_TAG_W], w_rd_data[ADC_DATA_W:1]};
`else
  assign w_wr_data = {i_ADC_Data, w_last};
  assign o_Tdata   = {{(AXIS_DATA_W-ADC_DATA_W){1'b0}}, w_rd_data[ADC_DATA_W:1]};
`endif

  adc_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (i_ADC_Data_Valid),
    .i_Wr_Data (w_wr_data),
    .o_Full    (w_fifo_full),
    .i_Rd_En   (i_Tready),
    .o_Rd_Data (w_rd_data),
    .o_Empty   (w_fifo_empty)
  );

  assign o_Tvalid = !w_fifo_empty;
  assign o_Tlast  = w_rd_data[0];

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_overflow <= w_set_overflow || (r_overflow && !i_Clear_Flags);
      r_missed   <= w_set_missed   || (r_missed   && !i_Clear_Flags);
    end
  end

  assign o_Overflow = r_overflow;
  assign o_Missed   = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_framer.sv
`default_nettype none
// ---- tb_adc_stream_framer : randomized scoreboard bench for adc_stream_framer ----
// ---- Rev 1.0                                                                  ----
module tb_adc_stream_framer;

  localparam int P  = 64;
  localparam int FL = 4;
  localparam int D  = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Enable = 1'b0;
  logic        i_ADC_Data_Valid = 1'b0;
  logic [11:0] i_ADC_Data = 12'h000;
  logic        i_Tready = 1'b0;
  logic        i_Clear_Flags = 1'b0;
  logic        o_ADC_Data_Requested;
  logic [15:0] o_Tdata;
  logic        o_Tvalid;
  logic        o_Tlast;
  logic        o_Overflow;
  logic        o_Missed;

  int checks = 0;
  int failures = 0;

  always #5 i_Clock = ~i_Clock;

  adc_stream_framer #(
    .SAMPLE_PERIOD_CLKS (P),
    .FRAME_LEN          (FL),
    .FIFO_DEPTH         (D)
  ) dut (
    .i_Clock              (i_Clock),
    .i_Reset_n            (i_Reset_n),
    .i_Enable             (i_Enable),
    .o_ADC_Data_Requested (o_ADC_Data_Requested),
    .i_ADC_Data_Valid     (i_ADC_Data_Valid),
    .i_ADC_Data           (i_ADC_Data),
    .o_Tdata              (o_Tdata),
    .o_Tvalid             (o_Tvalid),
    .i_Tready             (i_Tready),
    .o_Tlast              (o_Tlast),
    .o_Overflow           (o_Overflow),
    .o_Missed             (o_Missed),
    .i_Clear_Flags        (i_Clear_Flags)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  // Reference model state: abstract counters, not RTL registers.
  int m_run = 0;
  int m_occ = 0;
  int m_acc = 0;
  int m_strobes = 0;
  bit m_out = 0;
  bit m_ovf = 0;
  bit m_miss = 0;

  // Stimulus controls and reader model.
  int lat = 40;
  int rdy_pct = 100;
  int clr_pct = 0;
  bit rdy_on_strobe = 0;
  bit clr_on_strobe = 0;
  bit force_clr = 0;
  bit fixed_data = 1;
  bit pending = 0;
  int cd = 0;
  bit req_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts this cycle's outputs, then advances by the rules.
  always @(negedge i_Clock) begin
    bit    tick;
    bit    req;
    bit    full;
    bit    ovf_set;
    bit    miss_set;
    beat_t b;
    if (!i_Reset_n) begin
      m_run = 0; m_occ = 0; m_acc = 0; m_strobes = 0;
      m_out = 0; m_ovf = 0; m_miss = 0;
      exp_q.delete();
      check("rst_request", {31'd0, o_ADC_Data_Requested}, 32'd0);
      check("rst_tvalid",  {31'd0, o_Tvalid}, 32'd0);
      check("rst_flags",   {30'd0, o_Overflow, o_Missed}, 32'd0);
    end else begin
      tick = i_Enable && ((m_run % P) == 0);
      req  = tick && !m_out;
      check("request",  {31'd0, o_ADC_Data_Requested}, {31'd0, req});
      check("tvalid",   {31'd0, o_Tvalid}, {31'd0, (m_occ != 0)});
      check("overflow", {31'd0, o_Overflow}, {31'd0, m_ovf});
      check("missed",   {31'd0, o_Missed}, {31'd0, m_miss});
      miss_set = tick && m_out;
      full     = (m_occ == D);
      ovf_set  = i_ADC_Data_Valid && full;
      if (m_occ != 0 && i_Tready) m_occ--;
      if (i_ADC_Data_Valid && !full) begin
        b.data = {4'h0, i_ADC_Data};
`ifdef ADC_FRAMER_SEQ_TAG_EN
        b.data[15:12] = 4'(m_strobes % 16);
`endif
        b.last = ((m_acc % FL) == FL - 1);
        exp_q.push_back(b);
        m_acc++;
        m_occ++;
      end
      if (i_ADC_Data_Valid) m_strobes++;
      if (req) m_out = 1;
      else if (i_ADC_Data_Valid) m_out = 0;
      m_ovf  = ovf_set  || (m_ovf  && !i_Clear_Flags);
      m_miss = miss_set || (m_miss && !i_Clear_Flags);
      m_run  = i_Enable ? m_run + 1 : 0;
    end
  end

  // Monitor: compares every presented beat against the scoreboard head.
  always @(negedge i_Clock) begin
    if (i_Reset_n && o_Tvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual_tdata=0x%0h expected=no_beat t=%0t", o_Tdata, $time);
      end else begin
        check("tdata", {16'd0, o_Tdata}, {16'd0, exp_q[0].data});
        check("tlast", {31'd0, o_Tlast}, {31'd0, exp_q[0].last});
        if (i_Tready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge i_Clock);
    req_seen = o_ADC_Data_Requested;
    @(posedge i_Clock);
    #1;
    if (!i_Reset_n) begin
      pending = 0;
    end else if (req_seen) begin
      pending = 1;
      cd = lat - 1;
    end
    i_ADC_Data_Valid = 1'b0;
    if (pending) begin
      if (cd == 0) begin
        i_ADC_Data_Valid = 1'b1;
        pending = 0;
      end else begin
        cd--;
      end
    end
    i_ADC_Data    = i_ADC_Data_Valid ? (fixed_data ? 12'hABC : 12'($urandom)) : 12'h000;
    i_Tready      = rdy_on_strobe ? i_ADC_Data_Valid : (int'($urandom_range(99, 0)) < rdy_pct);
    i_Clear_Flags = force_clr || (clr_on_strobe && i_ADC_Data_Valid) ||
                    (int'($urandom_range(99, 0)) < clr_pct);
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_Enable = 1'b0;
    rdy_pct = 100;
    clr_pct = 0;
    while ((m_occ != 0 || pending || m_out) && n < 1000) begin
      cycle();
      n++;
    end
    cycle();
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) cycle();
    i_Reset_n = 1'b1;

    // Fixed 0xABC samples, latency 40: regular requests, frame of 4, no flags.
    i_Enable = 1'b1;
    lat = 40;
    repeat (9 * P + 60) cycle();

    // Latency longer than the period: misses, requests every other tick.
    lat = 100;
    repeat (4 * 2 * P) cycle();
    check("missed_sticky", {31'd0, o_Missed}, 32'd1);
    lat = 40;
    repeat (2 * P) cycle();
    force_clr = 1;
    cycle();
    force_clr = 0;

    // Back-pressure fills the FIFO; each overflow coincides with a clear.
    rdy_pct = 0;
    clr_on_strobe = 1;
    repeat (7 * P) cycle();
    check("overflow_set_wins", {31'd0, o_Overflow}, 32'd1);
    clr_on_strobe = 0;
    rdy_on_strobe = 1;
    repeat (3 * P) cycle();
    rdy_on_strobe = 0;
    rdy_pct = 100;
    repeat (30) cycle();
    force_clr = 1;
    cycle();
    force_clr = 0;
    cycle();
    check("overflow_cleared", {31'd0, o_Overflow}, 32'd0);

    // Randomized: latency, enable, ready and clear all vary.
    fixed_data = 0;
    for (int blk = 0; blk < 15; blk++) begin
      lat = int'($urandom_range(150, 5));
      i_Enable = (int'($urandom_range(99, 0)) < 80);
      rdy_pct = 70;
      clr_pct = 2;
      repeat (200) cycle();
    end
    drain();

    // Asynchronous reset with three buffered samples and a conversion pending.
    begin
      int n;
      bit hit;
      n = 0;
      hit = 0;
      i_Enable = 1'b1;
      lat = 60;
      rdy_pct = 0;
      while (!hit && n < 2000) begin
        cycle();
        n++;
        hit = (m_occ == 3) && pending;
      end
      checks++;
      if (!hit) begin
        failures++;
        $display("FAIL reset_setup_timeout actual_occ=%0d required_occ=3", m_occ);
      end
    end
    #2;
    i_Reset_n = 1'b0;
    #1;
    check("async_tvalid",  {31'd0, o_Tvalid}, 32'd0);
    check("async_request", {31'd0, o_ADC_Data_Requested}, 32'd0);
    check("async_tdata",   {16'd0, o_Tdata}, 32'd0);
    check("async_tlast",   {31'd0, o_Tlast}, 32'd0);
    pending = 0;
    repeat (3) cycle();
    i_Reset_n = 1'b1;
    lat = 20;
    rdy_pct = 100;
    repeat (6 * P) cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
